// File: rtl/calc_display_pkg.sv
// Shared types, constants and the lead-index mask helper for the calculator display formatter.
package calc_display_pkg;

   localparam int unsigned NIBBLE_W   = 4;
   localparam int unsigned MAX_DIGITS = 32;

   typedef enum logic [1:0] {
      ST_ENTRY,
      ST_SCAN,
      ST_HOLD,
      ST_ERROR
   } state_t;

   // Every digit blanked except digit 0, so an idle display reads "0".
   localparam logic [MAX_DIGITS-1:0] MASK_RESET = {{(MAX_DIGITS-1){1'b1}}, 1'b0};

   // Blank every digit above the leading digit; callers truncate to their digit count.
   function automatic logic [MAX_DIGITS-1:0] lead_mask(input int unsigned lead);
      logic [MAX_DIGITS-1:0] ones;
      ones = '1;
      return ones << (lead + 1);
   endfunction

endpackage

// File: rtl/calc_display_formatter_if.sv
// Result bus from the calculator FSM into the display formatter.
interface calc_display_formatter_if
   import calc_display_pkg::*;
#(
   parameter int unsigned DIGITS = 8
);
   logic [NIBBLE_W*DIGITS-1:0] result_data;
   logic                       result_valid;
   logic                       result_error;

   modport master (output result_data, result_valid, result_error);
   modport slave  (input  result_data, result_valid, result_error);
endinterface

// File: rtl/lead_digit_scanner.sv
// Latches a result word and walks down from the top digit to find the leading nonzero nibble.
module lead_digit_scanner
   import calc_display_pkg::*;
#(
   parameter int unsigned DIGITS = 8
)
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_start,
   input  logic                        i_abort,
   input  logic [NIBBLE_W*DIGITS-1:0]  i_data,
   output logic [NIBBLE_W*DIGITS-1:0]  o_shadow,
   output logic [$clog2(DIGITS)-1:0]   o_lead,
   output logic                        o_done
);
   localparam int unsigned IDX_W = $clog2(DIGITS);

   logic [DIGITS-1:0][NIBBLE_W-1:0] r_shadow;
   logic [IDX_W-1:0]                r_idx;
   logic                            r_active;

   // Digit 0 always terminates the scan so an all-zero result still shows "0".
   assign o_done   = r_active && ((r_shadow[r_idx] != '0) || (r_idx == '0));
   assign o_lead   = r_idx;
   assign o_shadow = r_shadow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active <= 1'b0;
         r_idx    <= '0;
         r_shadow <= '0;
      end else if (i_abort) begin
         r_active <= 1'b0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_idx    <= IDX_W'(DIGITS - 1);
         r_shadow <= i_data;
      end else if (o_done) begin
         r_active <= 1'b0;
      end else if (r_active) begin
         r_idx    <= r_idx - 1'b1;
      end
   end

endmodule

// File: rtl/calc_display_formatter.sv
// Builds the 7-segment value word and blank mask from live entry, a scanned result, or a blinking error.
module calc_display_formatter
   import calc_display_pkg::*;
#(
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned ENTRY_DIGITS = 4,
   parameter int unsigned BLINK_CYCLES = 4096
)
(
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NIBBLE_W*ENTRY_DIGITS-1:0]  entry_data,
   input  logic [NIBBLE_W-1:0]               entry_tag,
   input  logic                              entry_tag_en,
   calc_display_formatter_if.slave           res,
   input  logic                              clear,
   output logic [NIBBLE_W*DIGITS-1:0]        display,
   output logic [DIGITS-1:0]                 an_mask,
   output logic                              error_out,
   output logic                              busy,
   output logic                              holding
);
   localparam int unsigned     IDX_W    = $clog2(DIGITS);
   localparam int unsigned     CNT_W    = $clog2(BLINK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);
   localparam logic [DIGITS-1:0] MASK_RST = DIGITS'(MASK_RESET);

   state_t                          r_state, w_state_nxt;
   logic [NIBBLE_W*DIGITS-1:0]      r_display, w_display_nxt;
   logic [DIGITS-1:0]               r_an_mask, w_an_mask_nxt;
   logic [CNT_W-1:0]                r_blink_cnt, w_blink_cnt_nxt;
   logic                            r_blink_phase, w_blink_phase_nxt;

   logic                            w_scan_start;
   logic                            w_scan_done;
   logic [IDX_W-1:0]                w_scan_lead;
   logic [NIBBLE_W*DIGITS-1:0]      w_shadow;

   logic [ENTRY_DIGITS-1:0][NIBBLE_W-1:0] w_entry_nib;
   int unsigned                     w_entry_lead;
   logic [NIBBLE_W*DIGITS-1:0]      w_entry_display;
   logic [DIGITS-1:0]               w_entry_mask;

   lead_digit_scanner #(
      .DIGITS (DIGITS)
   ) u_scanner (
      .clk      (clk),
      .rst_n    (reset),
      .i_start  (w_scan_start),
      .i_abort  (clear),
      .i_data   (res.result_data),
      .o_shadow (w_shadow),
      .o_lead   (w_scan_lead),
      .o_done   (w_scan_done)
   );

   assign w_entry_nib = entry_data;

   always_comb begin
      w_entry_lead = 0;
      for (int unsigned k = 0; k < ENTRY_DIGITS; k++) begin
         if (w_entry_nib[k] != '0) w_entry_lead = k;
      end
      w_entry_mask = {~entry_tag_en, (DIGITS-1)'(lead_mask(w_entry_lead))};
      w_entry_display = '0;
      w_entry_display[NIBBLE_W*ENTRY_DIGITS-1:0] = entry_data;
      if (entry_tag_en) w_entry_display[NIBBLE_W*DIGITS-1 -: NIBBLE_W] = entry_tag;
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_display_nxt     = r_display;
      w_an_mask_nxt     = r_an_mask;
      w_blink_cnt_nxt   = r_blink_cnt;
      w_blink_phase_nxt = r_blink_phase;
      w_scan_start      = 1'b0;
      if (clear) begin
         // Clear beats a same-cycle result strobe; that result is dropped.
         w_state_nxt       = ST_ENTRY;
         w_display_nxt     = w_entry_display;
         w_an_mask_nxt     = w_entry_mask;
         w_blink_cnt_nxt   = '0;
         w_blink_phase_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_ENTRY: begin
               w_display_nxt = w_entry_display;
               w_an_mask_nxt = w_entry_mask;
               if (res.result_valid) begin
                  if (res.result_error) begin
                     w_state_nxt       = ST_ERROR;
                     w_display_nxt     = '0;
                     w_an_mask_nxt     = '0;
                     w_blink_cnt_nxt   = '0;
                     w_blink_phase_nxt = 1'b0;
                  end else begin
                     w_state_nxt  = ST_SCAN;
                     w_scan_start = 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               if (w_scan_done) begin
                  w_state_nxt   = ST_HOLD;
                  w_display_nxt = w_shadow;
                  w_an_mask_nxt = DIGITS'(lead_mask(32'(w_scan_lead)));
               end
            end
            ST_HOLD: begin
               w_state_nxt = ST_HOLD;
            end
            ST_ERROR: begin
               if (r_blink_cnt == CNT_LAST) begin
                  w_blink_cnt_nxt   = '0;
                  w_blink_phase_nxt = ~r_blink_phase;
               end else begin
                  w_blink_cnt_nxt   = r_blink_cnt + 1'b1;
               end
               w_display_nxt = '0;
               w_an_mask_nxt = {DIGITS{w_blink_phase_nxt}};
            end
            default: w_state_nxt = ST_ENTRY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_ENTRY;
         r_display     <= '0;
         r_an_mask     <= MASK_RST;
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_display     <= w_display_nxt;
         r_an_mask     <= w_an_mask_nxt;
         r_blink_cnt   <= w_blink_cnt_nxt;
         r_blink_phase <= w_blink_phase_nxt;
      end
   end

   assign display   = r_display;
   assign an_mask   = r_an_mask;
   assign error_out = (r_state == ST_ERROR);
   assign busy      = (r_state == ST_SCAN);
   assign holding   = (r_state == ST_HOLD) || (r_state == ST_ERROR);

endmodule
